// File: rtl/debug_cmd_sync_queue.sv
// Debug command queue, system-clock side of the virtual-JTAG debug slave.
// Synchronises the update-DR / update-IR levels from the tck domain into clk,
// captures {ir_in, sr} on each update-DR edge into a FIFO_DEPTH-entry queue and
// hands commands to the OCI core over a valid/ready handshake.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   vs_udr, vs_uir update-DR / update-IR levels (asynchronous to clk)
//   ir_in, sr      instruction code and scanned data, stable while vs_udr high
//   cmd_ready      consumer accepts the head command
//   overflow_clr   clears the sticky overflow flag
//   cmd_valid      queue non-empty, head command presented on cmd_ir / jdo
//   cmd_ir, jdo    head command (hold last value while empty)
//   take_action    one-hot pulse of the popped command's instruction
//   uir_pulse      one pulse per synchronised vs_uir rising edge
//   overflow       sticky: a command was dropped on a full queue
//   fill_level     current occupancy
module debug_cmd_sync_queue #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              vs_udr,
    input  logic                              vs_uir,
    input  logic [IR_W-1:0]                   ir_in,
    input  logic [DATA_W-1:0]                 sr,
    input  logic                              cmd_ready,
    input  logic                              overflow_clr,
    output logic                              cmd_valid,
    output logic [IR_W-1:0]                   cmd_ir,
    output logic [DATA_W-1:0]                 jdo,
    output logic [(1<<IR_W)-1:0]              take_action,
    output logic                              uir_pulse,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ACT_W = 1 << IR_W;
    localparam int unsigned ENT_W = IR_W + DATA_W;
    localparam int unsigned SET_W = 3;
    localparam logic [SET_W-1:0] SETTLE  = SET_W'(SYNC_STAGES + 1);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic [SET_W-1:0]       settle_cnt;
    logic                   settled;
    logic                   udr_rise;
    logic                   uir_rise;
    logic                   udr_pulse;

    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_nxt;
    logic [LVL_W-1:0]       fill_nxt;
    logic [ENT_W-1:0]       din;
    logic [ENT_W-1:0]       head_nxt;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;

    // Rising edges are ignored until the chains hold post-reset samples, so a
    // level already high at reset release is never mistaken for a new edge.
    assign settled  = (settle_cnt == SETTLE);
    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist & settled;
    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist & settled;

    // Synchronisers, history flops and registered edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync   <= '0;
            uir_sync   <= '0;
            udr_hist   <= 1'b0;
            uir_hist   <= 1'b0;
            settle_cnt <= '0;
            udr_pulse  <= 1'b0;
            uir_pulse  <= 1'b0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist  <= udr_sync[SYNC_STAGES-1];
            uir_hist  <= uir_sync[SYNC_STAGES-1];
            if (!settled) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            udr_pulse <= udr_rise;
            uir_pulse <= uir_rise;
        end
    end

    // Queue control: a full queue still accepts a push when the head pops.
    always_comb begin
        din      = {ir_in, sr};
        pop      = cmd_valid & cmd_ready;
        full     = (fill_level == DEPTH_L);
        wr_en    = udr_pulse & (~full | pop);
        drop     = udr_pulse & full & ~pop;
        rd_nxt   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        fill_nxt = fill_level + LVL_W'(wr_en) - LVL_W'(pop);
        // Next head bypasses the entry being written when it lands on the head slot.
        head_nxt = (wr_en && (rd_nxt == wr_ptr)) ? din : mem[rd_nxt];
    end

    // Storage array, no reset needed: head outputs are separately registered.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, head registers, action strobes and overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_level  <= '0;
            cmd_valid   <= 1'b0;
            cmd_ir      <= '0;
            jdo         <= '0;
            take_action <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_nxt;
            fill_level <= fill_nxt;
            cmd_valid  <= (fill_nxt != '0);
            if (fill_nxt != '0) begin
                {cmd_ir, jdo} <= head_nxt;
            end
            take_action <= pop ? (ACT_W'(1) << cmd_ir) : '0;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_sync_queue.sv
// Bench for debug_cmd_sync_queue: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// queue-based behavioural model.
module tb_debug_cmd_sync_queue;

    localparam int unsigned DATA_W      = 38;
    localparam int unsigned IR_W        = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FIFO_DEPTH  = 4;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                vs_udr = 1'b0;
    logic                vs_uir = 1'b0;
    logic [IR_W-1:0]     ir_in = '0;
    logic [DATA_W-1:0]   sr = '0;
    logic                cmd_ready = 1'b0;
    logic                overflow_clr = 1'b0;
    logic                cmd_valid;
    logic [IR_W-1:0]     cmd_ir;
    logic [DATA_W-1:0]   jdo;
    logic [3:0]          take_action;
    logic                uir_pulse;
    logic                overflow;
    logic [2:0]          fill_level;

    int checks = 0;
    int errors = 0;

    debug_cmd_sync_queue #(
        .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
        .uir_pulse(uir_pulse), .overflow(overflow), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a rising level first sampled on edge k becomes a push
    // on edge k+SYNC_STAGES+1 and a uir pulse visible after edge k+SYNC_STAGES.
    ent_t        mq[$];
    int          udr_due[$];
    int          uir_due[$];
    int          cyc = 0;
    logic        udr_prev = 1'b0;
    logic        uir_prev = 1'b0;
    logic        m_over = 1'b0;
    logic [3:0]  m_take = '0;
    logic        m_uir = 1'b0;
    ent_t        m_head = '0;

    always @(posedge clk or negedge reset_n) begin
        logic m_pop, m_push, m_drop;
        if (!reset_n) begin
            mq.delete();
            udr_due.delete();
            uir_due.delete();
            m_over   = 1'b0;
            m_take   = '0;
            m_uir    = 1'b0;
            m_head   = '0;
            udr_prev = vs_udr;
            uir_prev = vs_uir;
            cyc      = 0;
        end else begin
            cyc++;
            m_pop  = (mq.size() != 0) && cmd_ready;
            m_push = (udr_due.size() != 0) && (udr_due[0] == cyc);
            if (m_push) void'(udr_due.pop_front());
            m_uir = (uir_due.size() != 0) && (uir_due[0] == cyc);
            if (m_uir) void'(uir_due.pop_front());
            m_take = m_pop ? 4'(1 << mq[0].ir) : 4'd0;
            if (m_pop) void'(mq.pop_front());
            m_drop = 1'b0;
            if (m_push) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back({ir_in, sr});
                else m_drop = 1'b1;
            end
            if (m_drop) m_over = 1'b1;
            else if (overflow_clr) m_over = 1'b0;
            if (mq.size() != 0) m_head = mq[0];
            if (vs_udr && !udr_prev) udr_due.push_back(cyc + SYNC_STAGES + 1);
            if (vs_uir && !uir_prev) uir_due.push_back(cyc + SYNC_STAGES);
            udr_prev = vs_udr;
            uir_prev = vs_uir;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
            chk("m_fill_level", 64'(fill_level), 64'(mq.size()));
            chk("m_jdo", 64'(jdo), 64'(m_head.data));
            chk("m_cmd_ir", 64'(cmd_ir), 64'(m_head.ir));
            chk("m_take_action", 64'(take_action), 64'(m_take));
            chk("m_uir_pulse", 64'(uir_pulse), 64'(m_uir));
            chk("m_overflow", 64'(overflow), 64'(m_over));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic udr_cmd(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        wait_cyc(2);
        vs_udr = 1'b0;
        wait_cyc(3);
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        wait_cyc(1);
        cmd_ready = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_d [4];
        int ucnt, icnt;

        // Reset values
        wait_cyc(3);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        chk("rst_take_action", 64'(take_action), 64'd0);
        chk("rst_uir_pulse", 64'(uir_pulse), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_fill_level", 64'(fill_level), 64'd0);
        reset_n = 1'b1;
        wait_cyc(6);

        // Single command on an empty queue, consumer always ready
        cmd_ready = 1'b1;
        ir_in = 2'b01;
        sr = 38'h2A_DEAD_BEEF;
        vs_udr = 1'b1;
        wait_cyc(3);
        chk("single_valid_early", 64'(cmd_valid), 64'd0);
        wait_cyc(1);
        chk("single_valid_at4", 64'(cmd_valid), 64'd1);
        chk("single_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
        wait_cyc(1);
        chk("single_take", 64'(take_action), 64'b0010);
        chk("single_fill0", 64'(fill_level), 64'd0);
        wait_cyc(1);
        chk("single_take_off", 64'(take_action), 64'd0);
        vs_udr = 1'b0;
        cmd_ready = 1'b0;
        wait_cyc(3);

        // Fill and overflow, then drain in order
        for (int i = 1; i <= 5; i++) udr_cmd(IR_W'(i), DATA_W'(i));
        wait_cyc(2);
        chk("fill_level4", 64'(fill_level), 64'd4);
        chk("fill_overflow", 64'(overflow), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("fill_pop_jdo", 64'(jdo), 64'(k));
            pop_one();
            chk("fill_pop_take", 64'(take_action), 64'(1 << (k % 4)));
        end
        chk("fill_drained", 64'(fill_level), 64'd0);
        chk("fill_jdo_hold", 64'(jdo), 64'd4);

        // Clear overflow with no drop pending
        overflow_clr = 1'b1;
        wait_cyc(1);
        overflow_clr = 1'b0;
        chk("clr_overflow", 64'(overflow), 64'd0);

        // Full queue with push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            udr_cmd(IR_W'(i), DATA_W'(10 + i));
            exp_d[i] = DATA_W'(11 + i);
        end
        chk("pp_full", 64'(fill_level), 64'd4);
        ir_in = 2'd3;
        sr = 38'd14;
        vs_udr = 1'b1;
        wait_cyc(3);
        cmd_ready = 1'b1;
        wait_cyc(1);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        chk("pp_fill", 64'(fill_level), 64'd4);
        chk("pp_overflow", 64'(overflow), 64'd0);
        chk("pp_take", 64'(take_action), 64'b0001);
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", 64'(jdo), 64'(exp_d[k]));
            pop_one();
        end
        wait_cyc(2);

        // Long vs_udr level gives exactly one push
        ir_in = 2'd2;
        sr = 38'd77;
        vs_udr = 1'b1;
        wait_cyc(50);
        vs_udr = 1'b0;
        wait_cyc(3);
        chk("long_fill", 64'(fill_level), 64'd1);
        chk("long_jdo", 64'(jdo), 64'd77);
        pop_one();
        chk("long_take", 64'(take_action), 64'b0100);
        chk("long_fill0", 64'(fill_level), 64'd0);

        // vs_uir edge
        vs_uir = 1'b1;
        wait_cyc(2);
        chk("uir_early", 64'(uir_pulse), 64'd0);
        wait_cyc(1);
        chk("uir_at3", 64'(uir_pulse), 64'd1);
        chk("uir_queue", 64'(fill_level), 64'd0);
        wait_cyc(1);
        chk("uir_once", 64'(uir_pulse), 64'd0);
        wait_cyc(8);
        vs_uir = 1'b0;
        wait_cyc(3);

        // Overflow clear coinciding with a drop
        for (int i = 0; i < 5; i++) udr_cmd(IR_W'(i), DATA_W'(20 + i));
        chk("oc_set", 64'(overflow), 64'd1);
        ir_in = 2'd1;
        sr = 38'd25;
        vs_udr = 1'b1;
        wait_cyc(3);
        overflow_clr = 1'b1;
        wait_cyc(1);
        overflow_clr = 1'b0;
        chk("oc_set_wins", 64'(overflow), 64'd1);
        vs_udr = 1'b0;
        wait_cyc(3);
        overflow_clr = 1'b1;
        wait_cyc(1);
        overflow_clr = 1'b0;
        chk("oc_cleared", 64'(overflow), 64'd0);
        chk("oc_contents", 64'(jdo), 64'd20);

        // Asynchronous reset mid-queue, vs_udr held high across release
        #2;
        reset_n = 1'b0;
        vs_udr = 1'b1;
        #1;
        chk("arst_valid", 64'(cmd_valid), 64'd0);
        chk("arst_fill", 64'(fill_level), 64'd0);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(10);
        chk("arst_no_pulse", 64'(fill_level), 64'd0);
        vs_udr = 1'b0;
        wait_cyc(5);
        udr_cmd(2'd1, 38'd99);
        wait_cyc(1);
        chk("arst_new_push", 64'(fill_level), 64'd1);
        chk("arst_new_jdo", 64'(jdo), 64'd99);
        pop_one();

        // Randomized traffic against the model
        ucnt = 3;
        icnt = 3;
        for (int c = 0; c < 600; c++) begin
            cmd_ready    = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 7) == 0);
            if (ucnt == 0) begin
                vs_udr = ~vs_udr;
                if (vs_udr) begin
                    ir_in = IR_W'($urandom);
                    sr    = {6'($urandom), 32'($urandom)};
                end
                ucnt = $urandom_range(1, 4);
            end else begin
                ucnt--;
            end
            if (icnt == 0) begin
                vs_uir = ~vs_uir;
                icnt = $urandom_range(1, 6);
            end else begin
                icnt--;
            end
            wait_cyc(1);
        end
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        cmd_ready = 1'b1;
        overflow_clr = 1'b0;
        wait_cyc(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
